// File: rtl/i2s_tx.sv
// i2s_tx: parallel stereo sample to I2S serializer.
// One-sample holding register feeding a 32-bit frame shifter.
module i2s_tx #(
    parameter int BCLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rstb,
    input  logic [31:0] aud_in,
    input  logic        aud_in_rts,
    output logic        aud_in_rtr,
    input  logic        rf_i2s_en,
    input  logic        trig_i2s_underrun_clear,
    output logic        ro_i2s_underrun,
    output logic        i2s_bclk,
    output logic        i2s_lrclk,
    output logic        i2s_sdata
);

    localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(BCLK_DIV - 1);

    logic [DW-1:0] r_div_cnt;
    logic          r_bclk;
    logic [4:0]    r_bit_cnt;
    logic          r_lrclk;
    logic [31:0]   r_shreg;
    logic [31:0]   r_hold;
    logic          r_hold_valid;
    logic          r_underrun;

    logic          w_tc;
    logic          w_fall;
    logic          w_bnd;
    logic          w_xfer;
    logic [4:0]    w_bit_nxt;

    assign w_tc      = (r_div_cnt == DIV_MAX);
    assign w_fall    = w_tc & r_bclk;
    assign w_bnd     = rf_i2s_en & w_fall & (r_bit_cnt == 5'd31);
    assign w_bit_nxt = r_bit_cnt + 5'd1;
    assign w_xfer    = aud_in_rts & aud_in_rtr;

    assign aud_in_rtr      = rf_i2s_en & ~r_hold_valid;
    assign ro_i2s_underrun = r_underrun;
    assign i2s_bclk        = r_bclk;
    assign i2s_lrclk       = r_lrclk;
    assign i2s_sdata       = r_shreg[31];

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_div_cnt    <= '0;
            r_bclk       <= 1'b0;
            r_bit_cnt    <= 5'd31;
            r_lrclk      <= 1'b0;
            r_shreg      <= '0;
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
        end else if (!rf_i2s_en) begin
            r_div_cnt    <= '0;
            r_bclk       <= 1'b0;
            r_bit_cnt    <= 5'd31;
            r_lrclk      <= 1'b0;
            r_shreg      <= '0;
            r_hold_valid <= 1'b0;
        end else begin
            r_div_cnt <= w_tc ? '0 : r_div_cnt + DW'(1);
            if (w_tc) begin
                r_bclk <= ~r_bclk;
            end
            if (w_fall) begin
                r_bit_cnt <= w_bit_nxt;
                // lrclk leads each channel's MSB by one bit
                r_lrclk   <= (w_bit_nxt >= 5'd15) && (w_bit_nxt <= 5'd30);
                if (w_bnd) begin
                    r_shreg <= r_hold_valid ? r_hold : '0;
                end else begin
                    r_shreg <= {r_shreg[30:0], 1'b0};
                end
            end
            // a sample landing on the boundary edge waits for the next frame
            if (w_xfer) begin
                r_hold       <= aud_in;
                r_hold_valid <= 1'b1;
            end else if (w_bnd) begin
                r_hold_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_underrun <= 1'b0;
        end else if (w_bnd & ~r_hold_valid) begin
            r_underrun <= 1'b1;
        end else if (trig_i2s_underrun_clear) begin
            r_underrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: randomized scoreboard bench for i2s_tx.
// Frame-level reference model; monitor rebuilds words from bclk rises.
module tb_i2s_tx;

    localparam int B     = 2;
    localparam int FRAME = 64 * B;

    logic        clk = 1'b0;
    logic        rstb;
    logic [31:0] aud_in;
    logic        aud_in_rts;
    logic        aud_in_rtr;
    logic        rf_i2s_en;
    logic        trig;
    logic        ro_underrun;
    logic        bclk;
    logic        lrclk;
    logic        sdata;

    int checks = 0;
    int errors = 0;

    logic [31:0] hold_q[$];
    logic [31:0] exp_q[$];
    int          en_cnt = 0;
    bit          flag_m = 1'b0;
    bit          m_take;
    bit          m_bnd;
    bit          m_under;

    int          nr = 0;
    int          nb = 0;
    bit          prev_bclk = 1'b0;
    logic [31:0] mw = '0;
    logic [31:0] ml = '0;
    logic [31:0] me;

    always #5 clk = ~clk;

    i2s_tx #(.BCLK_DIV(B)) dut (
        .clk                     (clk),
        .rstb                    (rstb),
        .aud_in                  (aud_in),
        .aud_in_rts              (aud_in_rts),
        .aud_in_rtr              (aud_in_rtr),
        .rf_i2s_en               (rf_i2s_en),
        .trig_i2s_underrun_clear (trig),
        .ro_i2s_underrun         (ro_underrun),
        .i2s_bclk                (bclk),
        .i2s_lrclk               (lrclk),
        .i2s_sdata               (sdata)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Boundaries fall 2B cycles after enable, then every frame.
    function automatic bit is_bnd(input int n);
        return (n >= 2 * B) && (((n - 2 * B) % FRAME) == 0);
    endfunction

    initial forever begin
        @(posedge clk);
        if (!rstb) begin
            en_cnt = 0;
            hold_q.delete();
            exp_q.delete();
            flag_m = 1'b0;
        end else begin
            m_take  = rf_i2s_en && (hold_q.size() == 0);
            m_bnd   = rf_i2s_en && is_bnd(en_cnt + 1);
            m_under = m_bnd && (hold_q.size() == 0);
            if (rf_i2s_en) begin
                en_cnt++;
            end else begin
                en_cnt = 0;
                hold_q.delete();
                exp_q.delete();
            end
            if (m_bnd) begin
                if (m_under) exp_q.push_back(32'h0);
                else exp_q.push_back(hold_q.pop_front());
            end
            if (m_under) flag_m = 1'b1;
            else if (trig) flag_m = 1'b0;
            if (m_take && aud_in_rts) hold_q.push_back(aud_in);
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rstb || en_cnt == 0) begin
            if (rstb) begin
                chk("idle_bclk", 32'(bclk), 32'h0);
                chk("idle_lrclk", 32'(lrclk), 32'h0);
                chk("idle_sdata", 32'(sdata), 32'h0);
            end
            nr = 0;
            nb = 0;
            prev_bclk = 1'b0;
        end else begin
            if (!prev_bclk && bclk) begin
                if (nr == 0) begin
                    chk("prebit", {30'h0, lrclk, sdata}, 32'h0);
                end else begin
                    mw = {mw[30:0], sdata};
                    ml = {ml[30:0], lrclk};
                    nb++;
                    if (nb == 32) begin
                        nb = 0;
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL frame act=%h exp=none", mw);
                        end else begin
                            me = exp_q.pop_front();
                            chk("frame", mw, me);
                            chk("lrclk_pat", ml, 32'h0001FFFE);
                        end
                    end
                end
                nr++;
            end
            prev_bclk = bclk;
        end
        if (rstb) begin
            chk("rtr", 32'(aud_in_rtr),
                32'(rf_i2s_en && (hold_q.size() == 0)));
            chk("underrun", 32'(ro_underrun), 32'(flag_m));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w);
        int n = 0;
        aud_in     = w;
        aud_in_rts = 1'b1;
        @(negedge clk);
        while (!aud_in_rtr && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            checks++;
            errors++;
            $display("FAIL send_timeout act=stalled exp=accept w=%h", w);
        end
        @(posedge clk);
        #1;
        aud_in_rts = 1'b0;
    endtask

    task automatic wait_pre_bnd();
        int n = 0;
        do begin
            tick(1);
            n++;
        end while (!is_bnd(en_cnt + 1) && n < 400);
        if (n >= 400) begin
            checks++;
            errors++;
            $display("FAIL bnd_timeout act=none exp=boundary");
        end
    endtask

    task automatic pulse_clear();
        trig = 1'b1;
        tick(1);
        trig = 1'b0;
    endtask

    task automatic chk_reset_outs(input logic rtr_exp);
        chk("rst_bclk", 32'(bclk), 32'h0);
        chk("rst_lrclk", 32'(lrclk), 32'h0);
        chk("rst_sdata", 32'(sdata), 32'h0);
        chk("rst_underrun", 32'(ro_underrun), 32'h0);
        chk("rst_rtr", 32'(aud_in_rtr), 32'(rtr_exp));
    endtask

    initial begin
        rstb       = 1'b0;
        rf_i2s_en  = 1'b0;
        aud_in_rts = 1'b0;
        aud_in     = '0;
        trig       = 1'b0;
        tick(3);
        chk_reset_outs(1'b0);
        rstb      = 1'b1;
        rf_i2s_en = 1'b1;

        send(32'hA5A55A5A);
        tick(3 * FRAME);

        pulse_clear();
        wait_pre_bnd();
        tick(2);
        wait_pre_bnd();
        trig = 1'b1;
        tick(1);
        trig = 1'b0;

        pulse_clear();
        send(32'h11112222);
        send(32'h33334444);
        tick(2 * FRAME);

        wait_pre_bnd();
        tick(1);
        send(32'hCAFEF00D);
        tick(20 * B);
        rf_i2s_en = 1'b0;
        tick(4);
        rf_i2s_en = 1'b1;
        wait_pre_bnd();
        send(32'h7FFF8000);
        tick(3 * FRAME);

        for (int i = 0; i < 12; i++) begin
            tick($urandom_range(0, FRAME + 20));
            send($urandom);
            if ($urandom_range(0, 3) == 0) pulse_clear();
        end
        tick(2 * FRAME);

        send($urandom);
        tick(17);
        #1;
        rstb = 1'b0;
        #1;
        chk_reset_outs(1'b1);
        tick(3);
        rstb = 1'b1;
        send($urandom);
        send($urandom);
        tick(3 * FRAME);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2s_tx.md
# i2s_tx

Audio output serializer. It accepts 32-bit parallel stereo samples on the same rts/rtr handshake that the filter's `aud_out` side uses, and buffers one sample. It then shifts the sample out as a standard I2S stream (bclk, lrclk, sdata) toward the external DAC. It is the transmit end of the parallel audio path and sits after the filter in the chip's output chain.

## Interface
- `BCLK_DIV`, default 4: clk cycles per bclk half-period; legal range ≥1.
- `clk` input 1: master clock.
- `rstb` input 1: asynchronous, active-low reset.
- `aud_in` input 32: parallel sample; [31:16] left, [15:0] right, two's complement.
- `aud_in_rts` input 1: upstream ready to send.
- `aud_in_rtr` output 1: ready to receive; equals `rf_i2s_en & ~hold_valid`.
- `rf_i2s_en` input 1: block enable.
- `trig_i2s_underrun_clear` input 1: single-cycle pulse that clears the underrun flag.
- `ro_i2s_underrun` output 1: sticky underrun flag.
- `i2s_bclk` output 1: bit clock.
- `i2s_lrclk` output 1: word select; 0 = left, 1 = right.
- `i2s_sdata` output 1: serial data, MSB first.

## Operation
- **Holding register** (32 bits, plus `hold_valid`).
  - A transfer occurs on any clk edge where `aud_in_rts & aud_in_rtr`.
  - On transfer, `hold <= aud_in` and `hold_valid <= 1`.
- **Divider.** `div_cnt` counts 0..BCLK_DIV-1. At terminal count it wraps to 0 and `i2s_bclk` toggles.
- **Falling edge of bclk.** This is the clk cycle in which bclk toggles 1→0. On it:
  - `bit_cnt` (5 bits) increments and wraps 31→0.
  - **Frame boundary** (`bit_cnt` 31→0):
    - If `hold_valid=1`: `shreg <= hold` and `hold_valid <= 0`.
    - If `hold_valid=0`: `shreg <= 0` and `ro_i2s_underrun <= 1`.
  - **Otherwise:** `shreg <= {shreg[30:0], 1'b0}`.
  - **lrclk update:**
    - `i2s_lrclk <= 1` when new `bit_cnt` is 15..30.
    - `i2s_lrclk <= 0` when new `bit_cnt` is 31 or 0..14.
    - This makes lrclk change one bit before each channel's MSB, per I2S.
- `i2s_sdata = shreg[31]`. Data changes only on bclk falling edges and is stable across rising edges.
- **No bypass.** A sample accepted in the boundary cycle itself goes to `hold` and plays in the next frame.
- **Underrun flag.**
  - `trig_i2s_underrun_clear` clears the flag.
  - If set and clear occur in the same cycle, set wins.
  - The flag is unaffected by `rf_i2s_en`.
- **Disable** (`rf_i2s_en=0`), synchronous, taking effect the next clk:
  - `div_cnt`, bclk, `bit_cnt`, lrclk and `shreg` return to their reset values.
  - `hold_valid` is cleared and the pending sample is discarded.
  - `aud_in_rtr` = 0.
- **Reset state:** `div_cnt=0`, `i2s_bclk=0`, `bit_cnt=31`, `i2s_lrclk=0`, `shreg=0`, `i2s_sdata=0`, `hold_valid=0`, `ro_i2s_underrun=0`.
  - `aud_in_rtr` = `rf_i2s_en`.
  - Reset mid-frame aborts the frame immediately; outputs take reset values asynchronously.

## Timing
- bclk period = 2·BCLK_DIV clk cycles. Frame = 32 bclk = 64·BCLK_DIV clk cycles.
- **First edges after enable:**
  - First bclk rise: BCLK_DIV clk cycles after enable.
  - First falling edge: 2·BCLK_DIV clk cycles after enable. It is a frame boundary.
- **Accept to output:** MSB of left appears on `i2s_sdata` at the first frame boundary after `hold_valid=1`.
  - Minimum latency is 1 clk; maximum is one frame.
- **Left word:** 16 bits on `bit_cnt` 0..15 (lrclk=0 for bits 0..14, 1 at bit 15). Right word: `bit_cnt` 16..31.
- `aud_in_rtr` rises the clk after the boundary that consumes `hold`. At most one sample is accepted per frame.
- `ro_i2s_underrun` is asserted the clk after an empty-hold boundary.

## Test plan
- **Reset/idle.** Assert `rstb=0` mid-stream → all outputs at reset values within the same cycle, `bit_cnt=31`. Release with `rf_i2s_en=1` → `aud_in_rtr=1`, bclk starts toggling with period 2·BCLK_DIV.
- **Single sample.** BCLK_DIV=2; send `0xA5A55A5A` before the first boundary.
  - sdata bits, sampled on bclk rises, read 1010010110100101 with lrclk=0 (bit 15 has lrclk=1), then 0101101001011010.
  - No underrun.
- **Underrun.** Enable with no data → frame of zeros and `ro_i2s_underrun=1`.
  - Pulse clear → flag 0.
  - Next empty boundary sets it again.
  - Clear coincident with a boundary → flag stays 1.
- **Back-pressure.** Hold `aud_in_rts=1` with samples `0x11112222`, `0x33334444`.
  - Second sample stalls (`aud_in_rtr=0`) until the boundary loading the first.
  - Frames output in order, with no gaps or underrun.
- **Disable mid-frame.** Drop `rf_i2s_en` at `bit_cnt=10` with `hold_valid=1`.
  - Next clk: bclk=0, lrclk=0, sdata=0, `aud_in_rtr=0`, pending sample discarded.
  - Re-enable → first boundary underruns unless a new sample is supplied.
- **Boundary-cycle arrival.** Present `0x7FFF8000` exactly in a boundary cycle with hold empty → that frame is zeros with underrun set; the sample plays in the following frame.
